huffman_unary_decoder_param: RTL and testbench
==============================================

Name: huffman_unary_decoder_param

Overview:
Parametrised serial prefix-code decoder and the successor to the fixed 4-bit unary decoder. It consumes one code bit per accepted cycle. Codewords are unary: N zeros followed by a terminating 1 decode to symbol N. Beyond the fixed decoder, it adds configurable symbol width and maximum run, a truncated mode and an escape-literal mode, an output FIFO with ready/valid backpressure, and a symbol counter. It sits between the serial bitstream source and downstream symbol consumers.

Parameters:
SYM_W, 4, symbol/literal width in bits.
MAX_ZEROS, 15, zero-run limit; legal range 1..2^SYM_W-1.
FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.
CNT_W, 16, width of sym_count.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in  input  1  code bit.
in_valid  input  1  in carries a bit this cycle.
in_ready  output  1  decoder accepts a bit this cycle.
mode  input  1  0 = truncated unary, 1 = unary with escape literal.
out  output  SYM_W  decoded symbol at the FIFO head.
out_esc  output  1  head symbol came from an escape literal.
out_valid  output  1  FIFO non-empty.
out_ack  input  1  consumer takes the head entry this cycle.
sym_count  output  CNT_W  total symbols pushed since reset; wraps modulo 2^CNT_W.

Behaviour:
- Bit accepted when in_valid && in_ready. in_ready = !fifo_full, combinational. When in_valid is low, all state holds.
- FSM states are COUNT and LITERAL. zcnt is the zero counter, width ceil(log2(MAX_ZEROS+1)). lit_cnt counts literal bits collected.
- Effective mode is latched into mode_q at the first bit of each codeword (COUNT state, zcnt==0). Changes to mode mid-codeword have no effect until the next codeword.
- COUNT, bit 1: push {esc=0, sym=zcnt}, then zcnt<=0.
- COUNT, bit 0, zcnt+1 < MAX_ZEROS: zcnt<=zcnt+1.
- COUNT, bit 0, zcnt+1 == MAX_ZEROS, mode_q=0: push {0, MAX_ZEROS}, then zcnt<=0. No terminating 1 is consumed.
- COUNT, bit 0, zcnt+1 == MAX_ZEROS, mode_q=1: zcnt<=0, lit_cnt<=0, go to LITERAL. Nothing is pushed.
- LITERAL: each accepted bit shifts into the literal register MSB-first. After the SYM_W-th bit, push {1, literal} and return to COUNT.
- A push happens on the same edge that accepts the final bit. out_valid rises on the next cycle, so latency is 1 cycle from that edge.
- FIFO:
  - Pop when out_valid && out_ack.
  - Simultaneous push and pop is legal whenever in_ready is high; occupancy stays unchanged.
  - No push ever occurs while full.
  - Pop while empty is ignored.
  - Order is strictly FIFO.
- out and out_esc are driven 0 whenever out_valid=0.
- sym_count increments on every push.
- Reset (any cycle, including mid-codeword or mid-literal):
  - state=COUNT, zcnt=0, lit_cnt=0, literal=0, mode_q=0.
  - FIFO empty, out_valid=0, out=0, out_esc=0, sym_count=0.
  - in_ready=1 in the first cycle after reset.
  - All partial codewords are discarded.
- rst has priority over every other input in the same cycle.

Test Plan:
Defaults SYM_W=4, MAX_ZEROS=15, FIFO_DEPTH=4, out_ack=1 unless stated.
1. mode=0, bits 1,0,1,0,0,1 -> out 0,1,2 with out_esc=0; each symbol valid 1 cycle after its final bit; sym_count=3.
2. mode=0, 15 zeros then 1 -> symbol 15 pushed on the 15th zero, then symbol 0; sym_count=2.
3. mode=1, 15 zeros, then 1,0,1,0, then 1 -> {esc=1, out=10}, then {esc=0, out=0}; mode toggled to 0 during the zeros has no effect.
4. out_ack=0, stream 1,01,001,0001,00001 -> in_ready drops after the 4th push and the 5th codeword stalls with no bit lost. Pulse out_ack for 1 cycle -> in_ready returns, stream completes, and out_ack=1 then yields 0,1,2,3,4 in order.
5. Stream 0, in_valid low 7 cycles, 0, 1 -> single symbol 2; no pushes during the gap.
6. Bits 0,0, rst for 1 cycle, then 1 -> out 0, sym_count=1. Separately, a 2nd test with 15 zeros and 2 literal bits, rst, then 1 -> {esc=0, 0}.

Source files
------------

// File: rtl/huffman_unary_decoder_param.sv
// Serial unary prefix-code decoder: N zeros then a 1 -> symbol N, with a truncated
// mode, an escape-literal mode, an output FIFO with ready/valid and a symbol counter.
module huffman_unary_decoder_param #(
  parameter int SYM_W      = 4,
  parameter int MAX_ZEROS  = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  output logic [SYM_W-1:0] out,
  output logic             out_esc,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [CNT_W-1:0] sym_count
);

  localparam int ZW = $clog2(MAX_ZEROS + 1);
  localparam int LW = $clog2(SYM_W + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [ZW-1:0] ZLAST    = ZW'(MAX_ZEROS - 1);
  localparam logic [LW-1:0] LAST_LIT = LW'(SYM_W - 1);

  typedef struct packed {
    logic             esc;
    logic [SYM_W-1:0] sym;
  } entry_t;

  typedef enum logic {COUNT, LITERAL} state_t;

  state_t           state, state_n;
  logic [ZW-1:0]    zcnt, zcnt_n;
  logic [LW-1:0]    lit_cnt, lit_cnt_n;
  logic [SYM_W-1:0] literal, literal_n;
  logic             mode_q, mode_q_n, mode_eff;
  logic             accept, push, pop, full;
  entry_t           push_d;

  entry_t           mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop      = out_valid && out_ack;
  assign out      = out_valid ? mem[rptr].sym : '0;
  assign out_esc  = out_valid ? mem[rptr].esc : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= COUNT;
      zcnt    <= '0;
      lit_cnt <= '0;
      literal <= '0;
      mode_q  <= 1'b0;
    end else begin
      state   <= state_n;
      zcnt    <= zcnt_n;
      lit_cnt <= lit_cnt_n;
      literal <= literal_n;
      mode_q  <= mode_q_n;
    end
  end

  always_comb begin
    state_n    = state;
    zcnt_n     = zcnt;
    lit_cnt_n  = lit_cnt;
    literal_n  = literal;
    mode_q_n   = mode_q;
    push       = 1'b0;
    push_d     = '0;
    // The first bit of a codeword sees the live mode input, later bits the latched copy.
    mode_eff   = (state == COUNT && zcnt == '0) ? mode : mode_q;
    if (accept) begin
      case (state)
        COUNT: begin
          if (zcnt == '0) mode_q_n = mode;
          if (in) begin
            push       = 1'b1;
            push_d.sym = SYM_W'(zcnt);
            zcnt_n     = '0;
          end else if (zcnt != ZLAST) begin
            zcnt_n = zcnt + ZW'(1);
          end else if (!mode_eff) begin
            push       = 1'b1;
            push_d.sym = SYM_W'(MAX_ZEROS);
            zcnt_n     = '0;
          end else begin
            zcnt_n    = '0;
            lit_cnt_n = '0;
            state_n   = LITERAL;
          end
        end
        LITERAL: begin
          literal_n = SYM_W'({literal, in});
          lit_cnt_n = lit_cnt + LW'(1);
          if (lit_cnt == LAST_LIT) begin
            push       = 1'b1;
            push_d.esc = 1'b1;
            push_d.sym = literal_n;
            lit_cnt_n  = '0;
            state_n    = COUNT;
          end
        end
        default: state_n = COUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      sym_count <= '0;
    end else begin
      if (push) begin
        wptr      <= wptr + AW'(1);
        sym_count <= sym_count + CNT_W'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_huffman_unary_decoder_param.sv
// Randomized + directed scoreboard bench for huffman_unary_decoder_param.
module tb_huffman_unary_decoder_param;
  localparam int SYM_W = 4, MAX_Z = 15, DEPTH = 4, CNT_W = 16;

  logic clk = 1'b0;
  logic rst, in, in_valid, in_ready, mode, out_esc, out_valid, out_ack;
  logic [SYM_W-1:0] out;
  logic [CNT_W-1:0] sym_count;

  always #5 clk = ~clk;

  huffman_unary_decoder_param #(.SYM_W(SYM_W), .MAX_ZEROS(MAX_Z), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .out(out), .out_esc(out_esc), .out_valid(out_valid), .out_ack(out_ack), .sym_count(sym_count));

  typedef struct { logic esc; int sym; } exp_t;
  exp_t exp_q[$];
  int   cw[$];
  logic mq;
  int   model_cnt = 0;
  int   compared = 0, mismatched = 0;
  logic acc, rst_c, b_c, m_c;
  logic mon_en = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_push(logic esc, int sym);
    exp_t e;
    e.esc = esc;
    e.sym = sym;
    exp_q.push_back(e);
    model_cnt++;
    cw.delete();
  endfunction

  // Codeword-level reference: look at the whole bit list collected so far.
  function automatic void model_bit(logic b, logic m);
    int L, v;
    if (cw.size() == 0) mq = m;
    cw.push_back(int'(b));
    L = cw.size();
    if (L > MAX_Z) begin
      if (L == MAX_Z + SYM_W) begin
        v = 0;
        for (int i = MAX_Z; i < L; i++) v = v * 2 + cw[i];
        model_push(1'b1, v);
      end
    end else if (b) model_push(1'b0, L - 1);
    else if (L == MAX_Z && !mq) model_push(1'b0, MAX_Z);
  endfunction

  task automatic cyc();
    @(negedge clk);
    acc = in_valid && in_ready;
    rst_c = rst; b_c = in; m_c = mode;
    @(posedge clk);
    if (rst_c) begin
      cw.delete(); exp_q.delete(); model_cnt = 0;
    end else if (acc) model_bit(b_c, m_c);
    #1;
  endtask

  task automatic send_bit(logic b, logic m);
    bit done = 0;
    in = b; mode = m; in_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      cyc();
      if (acc) done = 1;
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic send_str(string s, logic m);
    for (int i = 0; i < s.len(); i++) send_bit(s[i] == "1", m);
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, exp_q.size() < DEPTH);
      check("sym_count", sym_count, model_cnt & ((1 << CNT_W) - 1));
      if (!out_valid) begin
        check("out_idle", out, 0);
        check("out_esc_idle", out_esc, 0);
      end else if (out_ack && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out", out, e.sym);
        check("out_esc", out_esc, e.esc);
      end
    end
  end

  initial begin
    rst = 1'b1; in = 1'b0; in_valid = 1'b0; mode = 1'b0; out_ack = 1'b1;
    cyc();
    mon_en = 1'b1;
    cyc();
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_sym_count", sym_count, 0);
    idle(1);

    send_str("101001", 1'b0);
    idle(3);
    check("t1_count", sym_count, 3);

    for (int i = 0; i < MAX_Z; i++) send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    idle(3);
    check("t2_count", sym_count, 5);

    for (int i = 0; i < MAX_Z; i++) send_bit(1'b0, (i == 0) ? 1'b1 : logic'(i % 2));
    send_str("1010", 1'b0);
    send_bit(1'b1, 1'b0);
    idle(3);

    out_ack = 1'b0;
    send_str("1010010001", 1'b0);
    idle(1);
    check("t4_stall", in_ready, 0);
    in = 1'b0; in_valid = 1'b1;
    repeat (3) cyc();
    out_ack = 1'b1;
    cyc();
    out_ack = 1'b0;
    send_str("00001", 1'b0);
    out_ack = 1'b1;
    idle(8);

    send_bit(1'b0, 1'b0);
    idle(7);
    send_str("01", 1'b0);
    idle(3);

    send_str("00", 1'b0);
    rst = 1'b1; in = 1'b1; in_valid = 1'b1;
    cyc();
    rst = 1'b0;
    send_bit(1'b1, 1'b0);
    idle(3);
    check("t6_count", sym_count, 1);
    for (int i = 0; i < MAX_Z; i++) send_bit(1'b0, 1'b1);
    send_str("10", 1'b1);
    rst = 1'b1; in_valid = 1'b0;
    cyc();
    rst = 1'b0;
    send_bit(1'b1, 1'b0);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      in       = ($urandom_range(0, 7) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      mode     = $urandom_range(0, 1);
      out_ack  = ($urandom_range(0, 9) < 6);
      rst      = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst = 1'b0; out_ack = 1'b1;
    idle(DEPTH + 4);
    check("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
